// File: rtl/seq_player.sv
// seq_player: digit-sequence player for one active-low 7-segment display.
//   A prescaler produces a one-cycle tick every DIV clocks. On each tick a small
//   SHOW/BLANK stepper moves the index through a LEN-entry, 4-bit sequence memory.
//   The memory can be rewritten at runtime.
// Ports: clk/rst (sync, active-high); cmd[1:0] step command, run auto-advance;
//   wr_en/wr_addr/wr_data memory write; tick prescaler pulse; idx current index;
//   blank FSM-in-BLANK flag; digit shown value (F when blank); seg {a..g}, active-low.
module seq_player #(
  parameter int               LEN  = 9,
  parameter int               DIV  = 50000000,
  parameter bit               WRAP = 1'b1,
  parameter logic [LEN*4-1:0] INIT = 36'h258240297,
  localparam int              AW   = $clog2(LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    cmd,
  input  logic          run,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [3:0]    wr_data,
  output logic          tick,
  output logic [AW-1:0] idx,
  output logic          blank,
  output logic [3:0]    digit,
  output logic [6:0]    seg
);

  localparam int            CW      = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [AW-1:0] IDX_MAX = AW'(LEN - 1);

  typedef enum logic {SHOW, BLANK} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] idx_nxt;
  logic [AW-1:0] idx_fwd;
  logic [AW-1:0] idx_bwd;
  logic [CW-1:0] cnt;
  logic [3:0]    mem [LEN];

  // Prescaler: tick is registered, so it is high in the cycle after cnt hit DIV-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == CNT_MAX);
      cnt  <= (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
    end
  end

  // End-of-sequence handling: wrap to the other end, or saturate in place.
  assign idx_fwd = (idx == IDX_MAX) ? (WRAP ? '0 : IDX_MAX) : idx + AW'(1);
  assign idx_bwd = (idx == '0)      ? (WRAP ? IDX_MAX : '0) : idx - AW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SHOW;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Commands are only honoured on tick edges; between ticks cmd/run are ignored.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    if (tick) begin
      case (state)
        SHOW: begin
          case (cmd)
            2'b11:   state_nxt = BLANK;   // idx kept so it stays visible on the port
            2'b01:   idx_nxt   = idx_bwd;
            2'b10:   idx_nxt   = idx_fwd;
            default: if (run) idx_nxt = idx_fwd;
          endcase
        end
        BLANK: begin
          // Leaving BLANK always restarts the sequence; run alone does not wake it.
          if (cmd == 2'b01 || cmd == 2'b10) begin
            state_nxt = SHOW;
            idx_nxt   = '0;
          end
        end
        default: begin
          state_nxt = SHOW;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  // Sequence memory; entry 0 is the leftmost nibble of INIT.
  // Out-of-range addresses are dropped so a non-power-of-two LEN cannot alias.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LEN; i++) begin
        mem[i] <= INIT[4*(LEN-1-i) +: 4];
      end
    end else if (wr_en && (32'(wr_addr) < 32'(LEN))) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign blank = (state == BLANK);
  assign digit = blank ? 4'hF : mem[idx];

  // Active-low decoder, bit order {a,b,c,d,e,f,g}; non-decimal values go dark.
  always_comb begin
    seg = 7'b1111111;
    case (digit)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = 7'b1111111;
    endcase
  end

endmodule
